// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control: opcodes, FSM states
// and the select/ALUOp encodings seen by the datapath and alu_control.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUOp values must stay in step with alu_control's decode.
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_IADD  = 2'b11;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_R_EXE,
        ST_R_WB,
        ST_BR,
        ST_I_EXE,
        ST_I_WB,
        ST_JMP
    } state_e;

    function automatic logic is_mem_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Bounded wait counter for memory handshakes: flags expiry on the WAIT_MAX-th
// consecutive cycle without ready.
module mc_wait_timer #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The count holds the number of wait cycles already completed, so the
    // cycle that sees LIMIT is the WAIT_MAX-th wait cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (active && !ready) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = active && !ready && (count_q == LIMIT);

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM with ready handshake and wait timeout.
// Define MC_CTRL_JUMP_EN to build the J instruction path (JMP state).
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic       mem_timeout
);

    state_e state_q;
    state_e state_d;
    logic   is_store_q;
    logic   is_store_d;
    logic   illegal_q;
    logic   illegal_d;
    logic   timeout_q;
    logic   timeout_d;
    logic   timer_active;
    logic   timer_clear;
    logic   timer_expired;

    assign timer_active = is_mem_wait_state(state_q);
    // Expiry in FETCH keeps the state, so it must clear the timer explicitly.
    assign timer_clear  = (state_d != state_q) || timer_expired;

    mc_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (timer_active),
        .ready   (mem_ready),
        .clear   (timer_clear),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            is_store_q <= 1'b0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // The load/store choice is latched in DECODE since opcode is not trusted later.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        illegal_d  = 1'b0;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RESET:    state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timer_expired) begin
                    timeout_d = 1'b1;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW: begin
                        state_d    = ST_MEM_ADDR;
                        is_store_d = 1'b0;
                    end
                    OP_SW: begin
                        state_d    = ST_MEM_ADDR;
                        is_store_d = 1'b1;
                    end
                    OP_RTYPE: state_d = ST_R_EXE;
                    OP_BNE:   state_d = ST_BR;
                    OP_ADDIU: state_d = ST_I_EXE;
`ifdef MC_CTRL_JUMP_EN
                    OP_J:     state_d = ST_JMP;
`endif
                    default: begin
                        state_d   = ST_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: state_d = is_store_q ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end else if (timer_expired) begin
                    state_d   = ST_FETCH;
                    timeout_d = 1'b1;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else if (timer_expired) begin
                    state_d   = ST_FETCH;
                    timeout_d = 1'b1;
                end
            end
            ST_MEM_WB:   state_d = ST_FETCH;
            ST_R_EXE:    state_d = ST_R_WB;
            ST_R_WB:     state_d = ST_FETCH;
            ST_BR:       state_d = ST_FETCH;
            ST_I_EXE:    state_d = ST_I_WB;
            ST_I_WB:     state_d = ST_FETCH;
`ifdef MC_CTRL_JUMP_EN
            ST_JMP:      state_d = ST_FETCH;
`endif
            default:     state_d = ST_FETCH;
        endcase
    end

    // Moore decode; only the FETCH write enables look at mem_ready directly.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_OP_ADD;
        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_R_EXE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_RTYPE;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_BR: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            ST_I_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_IADD;
            end
            ST_I_WB: begin
                reg_write = 1'b1;
            end
`ifdef MC_CTRL_JUMP_EN
            ST_JMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
`endif
            default: begin
            end
        endcase
    end

    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;

endmodule
